// File: rtl/pingpong_demux_ctrl.sv
// pingpong_demux_ctrl
// Sequencer in front of a 1-to-2 demultiplexer that feeds two ping-pong
// buffer banks. Accepts a valid/ready word stream and groups it into blocks
// of BLOCK_LEN words. After each complete block it marks the bank full and
// switches to the other bank. It stalls the stream while the next target
// bank still holds a block the consumer has not released.
module pingpong_demux_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int BLOCK_LEN  = 16,
  parameter int CNT_WIDTH  = 5
) (
  input  logic                  CLOCK_50,
  input  logic                  RESET_InHigh,
  input  logic [DATA_WIDTH-1:0] PPC_Data_in,
  input  logic                  PPC_Valid_in,
  output logic                  PPC_Ready_out,
  input  logic                  PPC_Release0,
  input  logic                  PPC_Release1,
  output logic [DATA_WIDTH-1:0] PPC_Data_out,
  output logic                  PPC_Selector,
  output logic                  PPC_En,
  output logic                  PPC_Full0,
  output logic                  PPC_Full1,
  output logic [CNT_WIDTH-1:0]  PPC_Count
);

  typedef enum logic {
    FILL  = 1'b0,
    STALL = 1'b1
  } state_t;

  localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(BLOCK_LEN - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  state_t                 state_q, state_d;
  logic                   bank_q, bank_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   full0_q, full0_d;
  logic                   full1_q, full1_d;

  logic [DATA_WIDTH-1:0]  data_p1;
  logic                   sel_p1;
  logic                   vld_p1;

  logic                   accept;
  logic                   last_word;
  logic                   ready;

  assign accept    = PPC_Valid_in & ready;
  assign last_word = accept & (cnt_q == LAST_IDX);

  // Word counter, bank pointer and full flags for the next cycle.
  // A release only clears a flag that is already set, and a flag set by the
  // last word of a block always wins over a release of the same bank.
  always_comb begin
    cnt_d   = cnt_q;
    bank_d  = bank_q;
    full0_d = full0_q & ~PPC_Release0;
    full1_d = full1_q & ~PPC_Release1;
    if (accept) begin
      if (last_word) begin
        cnt_d  = '0;
        bank_d = ~bank_q;
        if (bank_q == 1'b0) begin
          full0_d = 1'b1;
        end else begin
          full1_d = 1'b1;
        end
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  // Next-state logic: stall when the bank about to be filled is still full
  // once this cycle's releases have been applied.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL: begin
        if (last_word) begin
          state_d = (bank_d ? full1_d : full0_d) ? STALL : FILL;
        end
      end
      STALL: begin
        if (!(bank_q ? full1_d : full0_d)) begin
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // Ready depends only on registered state, and is held low during reset.
  always_comb begin
    ready = 1'b0;
    if (state_q == FILL) begin
      ready = ~RESET_InHigh;
    end
  end

  // State register plus control registers (bank, counter, full flags).
  always_ff @(posedge CLOCK_50) begin
    if (RESET_InHigh) begin
      state_q <= FILL;
      bank_q  <= 1'b0;
      cnt_q   <= '0;
      full0_q <= 1'b0;
      full1_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bank_q  <= bank_d;
      cnt_q   <= cnt_d;
      full0_q <= full0_d;
      full1_q <= full1_d;
    end
  end

  // ---- stage p1: registered demux word, selector and enable ----
  // The word and selector hold their last value when nothing is accepted.
  always_ff @(posedge CLOCK_50) begin
    if (RESET_InHigh) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      sel_p1  <= 1'b0;
    end else begin
      vld_p1 <= accept;
      if (accept) begin
        data_p1 <= PPC_Data_in;
        sel_p1  <= bank_q;
      end
    end
  end

  assign PPC_Ready_out = ready;
  assign PPC_Data_out  = data_p1;
  assign PPC_Selector  = sel_p1;
  assign PPC_En        = vld_p1;
  assign PPC_Full0     = full0_q;
  assign PPC_Full1     = full1_q;
  assign PPC_Count     = cnt_q;

endmodule

// File: tb/tb_pingpong_demux_ctrl.sv
// Testbench for pingpong_demux_ctrl: directed scenarios followed by random
// traffic, all compared against a block-level reference model.
module tb_pingpong_demux_ctrl;

  localparam int DW  = 8;
  localparam int BL  = 4;
  localparam int CW  = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] din = '0;
  logic          vin = 1'b0;
  logic          rdy;
  logic          rel0 = 1'b0;
  logic          rel1 = 1'b0;
  logic [DW-1:0] dout;
  logic          sel;
  logic          en;
  logic          full0;
  logic          full1;
  logic [CW-1:0] cnt;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: position inside the current block, which bank is
  // being written, and which banks hold an unreleased block.
  int            m_bank = 0;
  int            m_pos  = 0;
  bit            m_full [2];
  bit            m_en   = 0;
  bit [DW-1:0]   m_data = '0;
  bit            m_sel  = 0;

  always #5 clk = ~clk;

  pingpong_demux_ctrl #(
    .DATA_WIDTH(DW),
    .BLOCK_LEN (BL),
    .CNT_WIDTH (CW)
  ) dut (
    .CLOCK_50     (clk),
    .RESET_InHigh (rst),
    .PPC_Data_in  (din),
    .PPC_Valid_in (vin),
    .PPC_Ready_out(rdy),
    .PPC_Release0 (rel0),
    .PPC_Release1 (rel1),
    .PPC_Data_out (dout),
    .PPC_Selector (sel),
    .PPC_En       (en),
    .PPC_Full0    (full0),
    .PPC_Full1    (full1),
    .PPC_Count    (cnt)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check ready, advance model, check outputs.
  task automatic step(input bit r, input bit v, input bit [DW-1:0] d,
                      input bit r0, input bit r1);
    bit acc;
    @(negedge clk);
    rst  = r;
    vin  = v;
    din  = d;
    rel0 = r0;
    rel1 = r1;
    #1;
    check("ready", rdy, (!r && !m_full[m_bank]));
    if (r) begin
      m_bank = 0; m_pos = 0; m_full[0] = 0; m_full[1] = 0;
      m_en = 0; m_data = '0; m_sel = 0;
    end else begin
      acc = v && !m_full[m_bank];
      if (r0) m_full[0] = 0;
      if (r1) m_full[1] = 0;
      m_en = acc;
      if (acc) begin
        m_data = d;
        m_sel  = m_bank[0];
        m_pos  = m_pos + 1;
        if (m_pos == BL) begin
          m_pos = 0;
          m_full[m_bank] = 1;
          m_bank = 1 - m_bank;
        end
      end
    end
    @(posedge clk);
    #1;
    check("en",    en,    m_en);
    check("data",  dout,  m_data);
    check("sel",   sel,   m_sel);
    check("full0", full0, m_full[0]);
    check("full1", full1, m_full[1]);
    check("count", cnt,   m_pos);
  endtask

  initial begin
    // Reset
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    check("rst_en", en, 0);
    check("rst_count", cnt, 0);

    // Words 1..4 into bank 0
    for (int i = 1; i <= 4; i++) step(0, 1, 8'(i), 0, 0);
    check("blk0_full0", full0, 1);
    check("blk0_count", cnt, 0);
    check("blk0_sel", sel, 0);

    // Words 5..8 into bank 1, then hold word 9 while stalled
    for (int i = 5; i <= 8; i++) step(0, 1, 8'(i), 0, 0);
    check("blk1_full1", full1, 1);
    check("blk1_sel", sel, 1);
    step(0, 1, 8'd9, 0, 0);
    check("stall_en", en, 0);
    check("stall_ready", rdy, 0);

    // Release bank 0 while stalled; word 9 goes to bank 0 a cycle later
    step(0, 1, 8'd9, 1, 0);
    check("rel0_full0", full0, 0);
    step(0, 1, 8'd9, 0, 0);
    check("w9_en", en, 1);
    check("w9_sel", sel, 0);
    check("w9_data", dout, 9);

    // Words 10..12; last word coincides with release of bank 1
    step(0, 1, 8'd10, 0, 0);
    step(0, 1, 8'd11, 0, 0);
    step(0, 1, 8'd12, 0, 1);
    check("nb_full0", full0, 1);
    check("nb_full1", full1, 0);
    step(0, 1, 8'd13, 0, 0);
    check("nb_en", en, 1);
    check("nb_sel", sel, 1);

    // Release bank 0, then a redundant release while it is empty
    step(0, 0, 0, 1, 0);
    step(0, 1, 8'd14, 1, 0);
    check("redund_count", cnt, 2);
    check("redund_full0", full0, 0);

    // Reset mid-block
    step(1, 1, 8'd15, 0, 0);
    check("mid_rst_en", en, 0);
    check("mid_rst_count", cnt, 0);
    step(0, 1, 8'd16, 0, 0);
    check("post_rst_sel", sel, 0);
    check("post_rst_count", cnt, 1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 99) < 2,
           $urandom_range(0, 9) < 7,
           8'($urandom_range(0, 255)),
           $urandom_range(0, 99) < 15,
           $urandom_range(0, 99) < 15);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
